// File: rtl/input_encoder.sv
// input_encoder: serialises decoded worksheet records back into the puzzle
// ASCII byte stream. An argument is converted from binary to decimal with a
// sequential double-dabble and emitted most-significant digit first. An
// operand is emitted as '*' or '+'. Every field ends with ' ' or LF.
//
// Optional build macro:
//   INPUT_ENCODER_ALIGN_EN - left-pad every argument with spaces to DIGITS
//                            characters; operands are never padded.
module input_encoder #(
  parameter int ARG_DATA_WIDTH = 16,
  parameter int ARG_COL_WIDTH  = 10
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arg_valid,
  output logic                      arg_ready,
  input  logic [ARG_DATA_WIDTH-1:0] arg_data,
  input  logic                      arg_last,
  input  logic                      operand_valid,
  output logic                      operand_ready,
  input  logic                      operand_mult_add,
  input  logic                      operand_last,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic [7:0]                byte_data,
  output logic [ARG_COL_WIDTH-1:0]  col_count,
  output logic                      busy
);

  // Decimal digits needed for 2^W-1: ceil(W * log10(2)), fixed-point log10(2).
  localparam int DIGITS = int'((64'(ARG_DATA_WIDTH) * 64'd30103 + 64'd99999) / 64'd100000);
  localparam int BCD_W  = 4 * DIGITS;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W  = $clog2(ARG_DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] CONV_LAST = CNT_W'(ARG_DATA_WIDTH - 1);
  localparam logic [IDX_W-1:0] IDX_TOP   = IDX_W'(DIGITS - 1);

  localparam logic [7:0] CH_SPACE = 8'h20;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_MULT  = 8'h2A;
  localparam logic [7:0] CH_ADD   = 8'h2B;

  typedef enum logic [2:0] {
    IDLE,
    CONVERT,
    EMIT_DIGIT,
    EMIT_OP,
    EMIT_SEP
  } state_t;

  // One double-dabble step: correct every BCD nibble that would overflow
  // past 9 on doubling, then shift the BCD:binary pair left by one.
  function automatic logic [BCD_W+ARG_DATA_WIDTH-1:0] dabble_step(
    input logic [BCD_W-1:0]          bcd,
    input logic [ARG_DATA_WIDTH-1:0] bin
  );
    logic [BCD_W-1:0] adj;
    adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (adj[4*i +: 4] >= 4'd5) begin
        adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
      end
    end
    return {adj[BCD_W-2:0], bin, 1'b0};
  endfunction

  // Index of the most-significant nonzero nibble; 0 for a zero value so that
  // a single '0' is still emitted.
  function automatic logic [IDX_W-1:0] top_nonzero(input logic [BCD_W-1:0] bcd);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] != 4'd0) begin
        r = IDX_W'(i);
      end
    end
    return r;
  endfunction

  // Select one BCD nibble by digit index.
  function automatic logic [3:0] nibble_at(
    input logic [BCD_W-1:0] bcd,
    input logic [IDX_W-1:0] idx
  );
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IDX_W'(i) == idx) begin
        r = bcd[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t                     state_q, state_d;
  logic [BCD_W-1:0]           bcd_q, bcd_d;
  logic [ARG_DATA_WIDTH-1:0]  bin_q, bin_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       last_q, last_d;
  logic                       mult_q, mult_d;
  logic [ARG_COL_WIDTH-1:0]   col_q, col_d;
`ifdef INPUT_ENCODER_ALIGN_EN
  logic [IDX_W-1:0]           pad_q, pad_d;
`endif

  logic byte_hs;
  logic arg_acc;
  logic op_acc;

  // Ready and valid are pure decodes of the registered state; ready is
  // additionally held low while reset is asserted, and an argument offered
  // in the same cycle wins over an operand.
  always_comb begin
    arg_ready     = rst_n && (state_q == IDLE);
    operand_ready = rst_n && (state_q == IDLE) && !arg_valid;
    byte_valid    = (state_q == EMIT_DIGIT) || (state_q == EMIT_OP) ||
                    (state_q == EMIT_SEP);
    busy          = (state_q != IDLE);
    byte_hs       = byte_valid && byte_ready;
    arg_acc       = arg_valid && arg_ready;
    op_acc        = operand_valid && operand_ready;
    col_count     = col_q;
  end

  // Character currently offered to the sink; only depends on held state, so
  // it stays stable for as long as the sink stalls.
  always_comb begin
    byte_data = 8'h00;
    case (state_q)
      EMIT_DIGIT: begin
`ifdef INPUT_ENCODER_ALIGN_EN
        if (pad_q != '0) begin
          byte_data = CH_SPACE;
        end else begin
          byte_data = {4'h3, nibble_at(bcd_q, idx_q)};
        end
`else
        byte_data = {4'h3, nibble_at(bcd_q, idx_q)};
`endif
      end
      EMIT_OP:  byte_data = mult_q ? CH_MULT : CH_ADD;
      EMIT_SEP: byte_data = last_q ? CH_LF : CH_SPACE;
      default:  byte_data = 8'h00;
    endcase
  end

  // Next-state and datapath update for the field sequencer.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    bin_d   = bin_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    last_d  = last_q;
    mult_d  = mult_q;
    col_d   = col_q;
`ifdef INPUT_ENCODER_ALIGN_EN
    pad_d   = pad_q;
`endif

    case (state_q)
      IDLE: begin
        if (arg_acc) begin
          bin_d   = arg_data;
          bcd_d   = '0;
          cnt_d   = '0;
          last_d  = arg_last;
          state_d = CONVERT;
        end else if (op_acc) begin
          mult_d  = operand_mult_add;
          last_d  = operand_last;
          state_d = EMIT_OP;
        end
      end

      CONVERT: begin
        {bcd_d, bin_d} = dabble_step(bcd_q, bin_q);
        if (cnt_q == CONV_LAST) begin
          // The digit index comes from the fully converted value so the
          // first character is ready on the very next cycle.
          idx_d   = top_nonzero(bcd_d);
`ifdef INPUT_ENCODER_ALIGN_EN
          pad_d   = IDX_TOP - idx_d;
`endif
          state_d = EMIT_DIGIT;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      EMIT_DIGIT: begin
        if (byte_hs) begin
`ifdef INPUT_ENCODER_ALIGN_EN
          if (pad_q != '0) begin
            pad_d = pad_q - IDX_W'(1);
          end else if (idx_q == '0) begin
            state_d = EMIT_SEP;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
`else
          if (idx_q == '0) begin
            state_d = EMIT_SEP;
          end else begin
            idx_d = idx_q - IDX_W'(1);
          end
`endif
        end
      end

      EMIT_OP: begin
        if (byte_hs) begin
          state_d = EMIT_SEP;
        end
      end

      EMIT_SEP: begin
        if (byte_hs) begin
          // A row terminator restarts the column count; otherwise it wraps.
          col_d   = last_q ? '0 : col_q + ARG_COL_WIDTH'(1);
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any field in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bcd_q   <= '0;
      bin_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      mult_q  <= 1'b0;
      col_q   <= '0;
`ifdef INPUT_ENCODER_ALIGN_EN
      pad_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      bin_q   <= bin_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      mult_q  <= mult_d;
      col_q   <= col_d;
`ifdef INPUT_ENCODER_ALIGN_EN
      pad_q   <= pad_d;
`endif
    end
  end

  // Unused-in-some-builds guard: IDX_TOP only feeds the padding logic.
  logic unused_ok;
  assign unused_ok = ^IDX_TOP;

endmodule

// File: tb/tb_input_encoder.sv
// tb_input_encoder: directed bench for input_encoder (W=16). Honours
// INPUT_ENCODER_ALIGN_EN when building expected argument strings.
module tb_input_encoder;

  localparam int W   = 16;
  localparam int ACW = 10;

  logic           clk;
  logic           rst_n;
  logic           arg_valid;
  logic           arg_ready;
  logic [W-1:0]   arg_data;
  logic           arg_last;
  logic           operand_valid;
  logic           operand_ready;
  logic           operand_mult_add;
  logic           operand_last;
  logic           byte_valid;
  logic           byte_ready;
  logic [7:0]     byte_data;
  logic [ACW-1:0] col_count;
  logic           busy;

  int checks = 0;
  int errors = 0;
  logic [7:0] got[$];

  input_encoder #(
    .ARG_DATA_WIDTH(W),
    .ARG_COL_WIDTH (ACW)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .arg_valid       (arg_valid),
    .arg_ready       (arg_ready),
    .arg_data        (arg_data),
    .arg_last        (arg_last),
    .operand_valid   (operand_valid),
    .operand_ready   (operand_ready),
    .operand_mult_add(operand_mult_add),
    .operand_last    (operand_last),
    .byte_valid      (byte_valid),
    .byte_ready      (byte_ready),
    .byte_data       (byte_data),
    .col_count       (col_count),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Expected text of one argument field.
  function automatic string arg_text(input int v, input bit last);
    string s;
    s = $sformatf("%0d", v);
`ifdef INPUT_ENCODER_ALIGN_EN
    while (s.len() < 5) s = {" ", s};
`endif
    if (last) s = {s, "\n"};
    else      s = {s, " "};
    return s;
  endfunction

  // Offer an argument (optionally with a competing operand) and measure the
  // cycles from acceptance to the first valid byte. Ends at negedge+1.
  task automatic send_arg(input logic [W-1:0] v, input logic last, input bit with_op,
                          input string tag);
    int t;
    int lat;
    @(negedge clk);
    arg_valid = 1'b1;
    arg_data  = v;
    arg_last  = last;
    if (with_op) begin
      operand_valid    = 1'b1;
      operand_mult_add = 1'b1;
      operand_last     = 1'b0;
    end
    #1;
    t = 0;
    while (!arg_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_arg_ready"}, 32'(arg_ready), 32'd1);
    if (with_op) check({tag, "_op_ready_blocked"}, 32'(operand_ready), 32'd0);
    lat = 0;
    do begin
      @(negedge clk);
      arg_valid     = 1'b0;
      operand_valid = 1'b0;
      lat++;
      #1;
    end while (!byte_valid && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'(W + 1));
  endtask

  task automatic send_op(input logic mult, input logic last, input string tag);
    int t;
    int lat;
    @(negedge clk);
    operand_valid    = 1'b1;
    operand_mult_add = mult;
    operand_last     = last;
    #1;
    t = 0;
    while (!operand_ready && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    check({tag, "_op_ready"}, 32'(operand_ready), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      operand_valid = 1'b0;
      lat++;
      #1;
    end while (!byte_valid && lat < 100);
    check({tag, "_latency"}, 32'(lat), 32'd1);
  endtask

  // Collect n bytes. mode 0: always ready; mode 1: ready pattern 1,0,0,1.
  // Starts and ends at negedge+1; checks data stability while stalled.
  task automatic collect(input int n, input int mode, input string tag);
    int   k;
    int   c;
    logic stalled;
    logic [7:0] held;
    logic [3:0] pat;
    pat = 4'b1001;
    k = 0;
    c = 0;
    stalled = 1'b0;
    held = 8'h00;
    got.delete();
    while (k < n && c < 300) begin
      byte_ready = (mode == 0) ? 1'b1 : pat[c % 4];
      if (byte_valid) begin
        if (stalled) check({tag, "_hold"}, 32'(byte_data), 32'(held));
        if (byte_ready) begin
          got.push_back(byte_data);
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = byte_data;
        end
      end
      @(negedge clk);
      #1;
      c++;
    end
    byte_ready = 1'b0;
    check({tag, "_count"}, 32'(k), 32'(n));
  endtask

  task automatic expect_text(input string exp, input int mode, input string tag);
    collect(exp.len(), mode, tag);
    for (int i = 0; i < exp.len(); i++) begin
      check($sformatf("%s_byte%0d", tag, i),
            (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
    end
  endtask

  initial begin
    rst_n            = 1'b0;
    arg_valid        = 1'b0;
    arg_data         = '0;
    arg_last         = 1'b0;
    operand_valid    = 1'b0;
    operand_mult_add = 1'b0;
    operand_last     = 1'b0;
    byte_ready       = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_byte_valid", 32'(byte_valid), 32'd0);
    check("rst_byte_data", 32'(byte_data), 32'd0);
    check("rst_col_count", 32'(col_count), 32'd0);
    check("rst_arg_ready", 32'(arg_ready), 32'd0);
    check("rst_op_ready", 32'(operand_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    #1;
    check("post_rst_arg_ready", 32'(arg_ready), 32'd1);

    // "123 45\n"
    send_arg(16'd123, 1'b0, 1'b0, "a123");
    expect_text(arg_text(123, 1'b0), 0, "a123");
    check("a123_col", 32'(col_count), 32'd1);
    send_arg(16'd45, 1'b1, 1'b0, "a45");
    expect_text(arg_text(45, 1'b1), 0, "a45");
    check("a45_col", 32'(col_count), 32'd0);

    // Zero and full scale.
    send_arg(16'd0, 1'b0, 1'b0, "a0");
    expect_text(arg_text(0, 1'b0), 0, "a0");
    check("a0_col", 32'(col_count), 32'd1);
    send_arg(16'hFFFF, 1'b1, 1'b0, "amax");
    expect_text(arg_text(65535, 1'b1), 0, "amax");
    check("amax_col", 32'(col_count), 32'd0);

    // Operands: "* +\n"
    send_op(1'b1, 1'b0, "opm");
    expect_text("* ", 0, "opm");
    check("opm_col", 32'(col_count), 32'd1);
    send_op(1'b0, 1'b1, "opa");
    expect_text("+\n", 0, "opa");
    check("opa_col", 32'(col_count), 32'd0);

    // Arg and operand together: argument path taken.
    send_arg(16'd5, 1'b1, 1'b1, "coll");
    expect_text(arg_text(5, 1'b1), 0, "coll");
    check("coll_idle", 32'(busy), 32'd0);

    // Back-pressure.
    send_arg(16'd987, 1'b0, 1'b0, "a987");
    expect_text(arg_text(987, 1'b0), 1, "a987");
    check("a987_col", 32'(col_count), 32'd1);

    // Reset in the middle of digit emission.
    send_arg(16'd4321, 1'b0, 1'b0, "a4321");
    collect(2, 0, "a4321_part");
    check("a4321_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_byte_valid", 32'(byte_valid), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_arg_ready", 32'(arg_ready), 32'd0);
    check("midrst_col", 32'(col_count), 32'd0);
    rst_n = 1'b1;
    #1;
    check("midrst_release_ready", 32'(arg_ready), 32'd1);

    // Interior zero digits.
    send_arg(16'd100, 1'b1, 1'b0, "a100");
    expect_text(arg_text(100, 1'b1), 0, "a100");
    check("a100_col", 32'(col_count), 32'd0);

`ifdef INPUT_ENCODER_ALIGN_EN
    send_arg(16'd7, 1'b0, 1'b0, "a7pad");
    expect_text("    7 ", 0, "a7pad");
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
